// File: rtl/serial_to_parallel_if.sv
// Handshake bundle for the serial-to-parallel deserializer: serial input side and word output side.
interface serial_to_parallel_if #(
    parameter int unsigned WIDTH = 8
);
    logic             s_valid;
    logic             s_ready;
    logic             s_data;
    logic             s_sync;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             sync_err;

    modport slave (
        input  s_valid, s_data, s_sync, m_ready,
        output s_ready, m_valid, m_data, sync_err
    );

    modport master (
        output s_valid, s_data, s_sync, m_ready,
        input  s_ready, m_valid, m_data, sync_err
    );
endinterface

// File: rtl/serial_to_parallel.sv
// Deserializer: gathers 1-bit serial transfers into WIDTH-bit words behind a valid/ready output register.
module serial_to_parallel #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    serial_to_parallel_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_sync_err;

    logic             w_last;
    logic             w_s_ready;
    logic             w_in_xfer;
    logic [CW-1:0]    w_eff;
    logic [CW-1:0]    w_idx;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;

    // Only the completing bit can stall, and only when the output is full and not draining.
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_s_ready  = !w_last || !r_m_valid || bus.m_ready;
    assign w_in_xfer  = bus.s_valid && w_s_ready;
    assign w_eff      = bus.s_sync ? CW'(0) : r_cnt;
    assign w_idx      = MSB_FIRST ? (CW'(WIDTH - 1) - w_eff) : w_eff;
    assign w_complete = w_in_xfer && (w_eff == CW'(WIDTH - 1));

    // Partial word with the incoming bit merged at its slot.
    always_comb begin
        w_word        = r_shift;
        w_word[w_idx] = bus.s_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_in_xfer && bus.s_sync && (r_cnt != CW'(0));
            if (r_m_valid && bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_in_xfer) begin
                if (w_complete) begin
                    r_m_data  <= w_word;
                    r_m_valid <= 1'b1;
                    r_cnt     <= '0;
                end else begin
                    r_shift <= w_word;
                    r_cnt   <= w_eff + CW'(1);
                end
            end
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_data   = r_m_data;
    assign bus.sync_err = r_sync_err;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: LSB-first and MSB-first instances driven in lockstep against a queue model.
module tb_serial_to_parallel;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_to_parallel_if #(.WIDTH(W)) if0 ();
    serial_to_parallel_if #(.WIDTH(W)) if1 ();

    serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
    serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));

    int total = 0;
    int bad   = 0;

    // Model: accepted bits of the current word, plus the output register contents.
    bit         q[$];
    bit         mv;
    logic [7:0] md0, md1;
    bit         merr;
    bit         last_sr;

    typedef struct {
        bit         v, d, sy, mr;
        bit         ev;
        logic [7:0] ed0, ed1;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack(input bit msb);
        logic [7:0] w = '0;
        for (int i = 0; i < int'(W); i++) w[msb ? (int'(W) - 1 - i) : i] = q[i];
        return w;
    endfunction

    task automatic drive(input bit v, d, sy, mr);
        if0.s_valid = v; if0.s_data = d; if0.s_sync = sy; if0.m_ready = mr;
        if1.s_valid = v; if1.s_data = d; if1.s_sync = sy; if1.m_ready = mr;
    endtask

    // One clock: drive, check s_ready, advance model, then check registered outputs.
    task automatic step(input bit rst, v, d, sy, mr);
        bit exp_sr, xin;
        rst_n = !rst;
        drive(v, d, sy, mr);
        #1;
        exp_sr = (q.size() != W - 1) || !mv || mr;
        chk("s_ready0", 32'(if0.s_ready), 32'(exp_sr));
        chk("s_ready1", 32'(if1.s_ready), 32'(exp_sr));
        last_sr = if0.s_ready;
        if (rst) begin
            q.delete(); mv = 0; md0 = '0; md1 = '0; merr = 0;
        end else begin
            xin  = v && exp_sr;
            merr = xin && sy && (q.size() != 0);
            if (mv && mr) mv = 0;
            if (xin) begin
                if (sy) q.delete();
                q.push_back(d);
                if (q.size() == W) begin
                    md0 = pack(1'b0); md1 = pack(1'b1); mv = 1; q.delete();
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("m_valid0", 32'(if0.m_valid), 32'(mv));
        chk("m_valid1", 32'(if1.m_valid), 32'(mv));
        chk("m_data0", 32'(if0.m_data), 32'(md0));
        chk("m_data1", 32'(if1.m_data), 32'(md1));
        chk("sync_err0", 32'(if0.sync_err), 32'(merr));
        chk("sync_err1", 32'(if1.sync_err), 32'(merr));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit mr);
        for (int i = 0; i < int'(W); i++) step(1'b0, 1'b1, b[i], 1'b0, mr);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int first_pulse;
        int pulses;
        bit sr_all;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mv = 0; md0 = '0; md1 = '0; merr = 0;
        @(negedge clk);
        do_reset();
        chk("reset_m_valid", 32'(if0.m_valid), 32'd0);
        chk("reset_m_data", 32'(if0.m_data), 32'd0);

        // Bits 1,0,1,1,0,0,0,0 -> 0x0D LSB-first, 0xB0 MSB-first.
        tbl[0] = '{1, 1, 0, 1, 0, 8'h00, 8'h00};
        tbl[1] = '{1, 0, 0, 1, 0, 8'h00, 8'h00};
        tbl[2] = '{1, 1, 0, 1, 0, 8'h00, 8'h00};
        tbl[3] = '{1, 1, 0, 1, 0, 8'h00, 8'h00};
        tbl[4] = '{1, 0, 0, 1, 0, 8'h00, 8'h00};
        tbl[5] = '{1, 0, 0, 1, 0, 8'h00, 8'h00};
        tbl[6] = '{1, 0, 0, 1, 0, 8'h00, 8'h00};
        tbl[7] = '{1, 0, 0, 1, 1, 8'h0D, 8'hB0};
        tbl[8] = '{0, 0, 0, 1, 0, 8'h0D, 8'hB0};
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i].v, tbl[i].d, tbl[i].sy, tbl[i].mr);
            chk("tbl_m_valid", 32'(if0.m_valid), 32'(tbl[i].ev));
            chk("tbl_m_data_lsb", 32'(if0.m_data), 32'(tbl[i].ed0));
            chk("tbl_m_data_msb", 32'(if1.m_data), 32'(tbl[i].ed1));
        end

        // Backpressure: A5 held, 16th bit stalls until m_ready rises, B follows without a bubble.
        do_reset();
        send_byte(8'hA5, 1'b0);
        chk("bp_a_valid", 32'(if0.m_valid), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'(8'h3C >> i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_stall_sready", 32'(last_sr), 32'd0);
        chk("bp_hold_data", 32'(if0.m_data), 32'hA5);
        chk("bp_hold_valid", 32'(if0.m_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp_release_sready", 32'(last_sr), 32'd1);
        chk("bp_b_data", 32'(if0.m_data), 32'h3C);
        chk("bp_b_valid", 32'(if0.m_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_drained", 32'(if0.m_valid), 32'd0);

        // Streaming: 24 bits, one m_valid pulse every 8 cycles, s_ready never drops.
        do_reset();
        pulses = 0; first_pulse = -1; sr_all = 1;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            sr_all &= last_sr;
            chk("stream_pulse", 32'(if0.m_valid), 32'((i % 8) == 7));
            if (if0.m_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        chk("stream_pulses", 32'(pulses), 32'd3);
        chk("stream_first", 32'(first_pulse), 32'd7);
        chk("stream_sready", 32'(sr_all), 32'd1);

        // Mid-word sync: partial bits dropped, one error pulse.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("sync_err_pulse", 32'(if0.sync_err), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sync_err_clear", 32'(if0.sync_err), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sync_word", 32'(if0.m_data), 32'h01);
        chk("sync_word_msb", 32'(if1.m_data), 32'h80);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("sync_at_zero_no_err", 32'(if0.sync_err), 32'd0);

        // Reset mid-word and with a pending word.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h5A, 1'b0);
        chk("rst_mid_word", 32'(if0.m_data), 32'h5A);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid_drop", 32'(if0.m_valid), 32'd0);
        chk("rst_data_clear", 32'(if0.m_data), 32'd0);
        send_byte(8'hC3, 1'b1);
        chk("rst_clean_word", 32'(if0.m_data), 32'hC3);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, ($urandom % 4) != 0, 1'($urandom),
                 $urandom_range(0, 15) == 0, ($urandom % 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
